// File: rtl/vga_timing_pkg.sv
// Shared timing constants and types for the VGA scan generator.
// Defaults describe 640x480@60 on a 25.175 MHz pixel clock.
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    // Vertical timing, in lines
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Derived totals and sync windows for the default mode
    localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    // Coordinate counters are 10 bits wide; totals above this cannot be represented
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned COORD_MAX = 1 << COORD_W;

    typedef logic [COORD_W-1:0] coord_t;

    // True when c lies in the inclusive window [lo, hi]
    function automatic logic in_window(coord_t c, int unsigned lo, int unsigned hi);
        return (32'(c) >= lo) && (32'(c) <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// DEPTH x WIDTH shift register with asynchronous active-low reset to a per-bit value.
// Used to align sync/active flags with downstream pixel data latency.
module sync_delay_line #(
    parameter int unsigned          DEPTH   = 2,
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // A zero-depth line is handled by the caller as a plain wire
    if (DEPTH < 1) begin : g_bad_depth
        $error("sync_delay_line: DEPTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift one stage per clock; reset flushes every stage to the inactive value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan generator: pixel/line counters, registered sync and active-video decode,
// line/frame strobes, a frame counter, and delayed flag copies aligned to mapper RGB.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned PIPE_DELAY  = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        blank_d,
    output logic        hs_d,
    output logic        vs_d,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);

    if ((H_TOTAL > COORD_MAX) || (V_TOTAL > COORD_MAX)) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end

    coord_t      draw_x_q, draw_x_d;
    coord_t      draw_y_q, draw_y_d;
    logic        frame_wrap;
    logic [15:0] frame_cnt_q;
    logic        active_q, active_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_strb_q, line_strb_d;
    logic        frame_strb_q, frame_strb_d;

    // Next-state counters: X wraps every line, Y advances only on the X wrap
    always_comb begin
        draw_x_d   = draw_x_q + 10'd1;
        draw_y_d   = draw_y_q;
        frame_wrap = 1'b0;
        if (draw_x_q == H_LAST) begin
            draw_x_d = '0;
            if (draw_y_q == V_LAST) begin
                draw_y_d   = '0;
                frame_wrap = 1'b1;
            end else begin
                draw_y_d = draw_y_q + 10'd1;
            end
        end
    end

    // Decode from next-state coordinates so the registered flags match the registered counters
    always_comb begin
        active_d     = (draw_x_d < H_ACT_C) && (draw_y_d < V_ACT_C);
        hsync_d      = in_window(draw_x_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d      = in_window(draw_y_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        line_strb_d  = (draw_x_d == '0);
        frame_strb_d = (draw_x_d == '0) && (draw_y_d == '0);
    end

    // Scan state register; strobes stay low in the reset state so the first pulse is at a wrap
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_x_q     <= '0;
            draw_y_q     <= '0;
            frame_cnt_q  <= '0;
            active_q     <= 1'b1;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            line_strb_q  <= 1'b0;
            frame_strb_q <= 1'b0;
        end else begin
            draw_x_q     <= draw_x_d;
            draw_y_q     <= draw_y_d;
            active_q     <= active_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            line_strb_q  <= line_strb_d;
            frame_strb_q <= frame_strb_d;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign blank       = active_q;
    assign hs          = hsync_q;
    assign vs          = vsync_q;
    assign line_start  = line_strb_q;
    assign frame_start = frame_strb_q;
    assign frame_count = frame_cnt_q;

    // Flag bundle order {blank, hs, vs}; delayed copies reset to inactive (blank low, syncs idle)
    logic [2:0] flags, flags_dly;
    assign flags = {active_q, hsync_q, vsync_q};

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign flags_dly = flags;
    end else begin : g_delay
        sync_delay_line #(
            .DEPTH   (PIPE_DELAY),
            .WIDTH   (3),
            .RST_VAL ({1'b0, ~SYNC_ACTIVE, ~SYNC_ACTIVE})
        ) u_flag_delay (
            .clk   (vga_clk),
            .rst_n (reset_n),
            .din   (flags),
            .dout  (flags_dly)
        );
    end

    assign blank_d = flags_dly[2];
    assign hs_d    = flags_dly[1];
    assign vs_d    = flags_dly[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance for line-level checks and
// two reduced-timing instances (16 x 11 scan) for frame-level, polarity and delay checks.
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Default 640x480 instance, PIPE_DELAY=2, active-low syncs
    logic [9:0]  f_x, f_y;
    logic        f_blank, f_hs, f_vs, f_blank_d, f_hs_d, f_vs_d, f_ls, f_fs;
    logic [15:0] f_fc;

    // Small instance: H 8/2/3/3 (16), V 6/1/2/2 (11), 176 clocks/frame, PIPE_DELAY=2
    logic [9:0]  s_x, s_y;
    logic        s_blank, s_hs, s_vs, s_blank_d, s_hs_d, s_vs_d, s_ls, s_fs;
    logic [15:0] s_fc;

    // Same small timing, active-high syncs, PIPE_DELAY=0
    logic [9:0]  z_x, z_y;
    logic        z_blank, z_hs, z_vs, z_blank_d, z_hs_d, z_vs_d, z_ls, z_fs;
    logic [15:0] z_fc;

    vga_timing_gen dut_full (
        .vga_clk     (clk),
        .reset_n     (rst_n),
        .DrawX       (f_x),
        .DrawY       (f_y),
        .blank       (f_blank),
        .hs          (f_hs),
        .vs          (f_vs),
        .blank_d     (f_blank_d),
        .hs_d        (f_hs_d),
        .vs_d        (f_vs_d),
        .line_start  (f_ls),
        .frame_start (f_fs),
        .frame_count (f_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_ACTIVE (1'b0), .PIPE_DELAY (2)
    ) dut_small (
        .vga_clk     (clk),
        .reset_n     (rst_n),
        .DrawX       (s_x),
        .DrawY       (s_y),
        .blank       (s_blank),
        .hs          (s_hs),
        .vs          (s_vs),
        .blank_d     (s_blank_d),
        .hs_d        (s_hs_d),
        .vs_d        (s_vs_d),
        .line_start  (s_ls),
        .frame_start (s_fs),
        .frame_count (s_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_ACTIVE (1'b1), .PIPE_DELAY (0)
    ) dut_zero (
        .vga_clk     (clk),
        .reset_n     (rst_n),
        .DrawX       (z_x),
        .DrawY       (z_y),
        .blank       (z_blank),
        .hs          (z_hs),
        .vs          (z_vs),
        .blank_d     (z_blank_d),
        .hs_d        (z_hs_d),
        .vs_d        (z_vs_d),
        .line_start  (z_ls),
        .frame_start (z_fs),
        .frame_count (z_fc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int f_hs_low, f_hs_first, f_ls_cnt, f_align;
    int s_vs_low, s_vs_first, s_fs_cnt, s_ls_cnt, s_align;
    int z_hs_high, z_hs_first, z_vs_high, z_align;
    int found, lat;
    logic [2:0] fp1, fp2, sp1, sp2;

    initial begin
        f_hs_low = 0; f_hs_first = -1; f_ls_cnt = 0; f_align = 0;
        s_vs_low = 0; s_vs_first = -1; s_fs_cnt = 0; s_ls_cnt = 0; s_align = 0;
        z_hs_high = 0; z_hs_first = -1; z_vs_high = 0; z_align = 0;

        // Reset state, sampled while reset is held
        tick();
        tick();
        check_eq("rst_drawx", f_x, 0);
        check_eq("rst_drawy", f_y, 0);
        check_eq("rst_blank", f_blank, 1);
        check_eq("rst_hs", f_hs, 1);
        check_eq("rst_vs", f_vs, 1);
        check_eq("rst_line_start", f_ls, 0);
        check_eq("rst_frame_start", f_fs, 0);
        check_eq("rst_frame_count", f_fc, 0);
        check_eq("rst_blank_d", f_blank_d, 0);
        check_eq("rst_hs_d", f_hs_d, 1);
        check_eq("rst_vs_d", f_vs_d, 1);
        check_eq("rst_hs_pos_pol", z_hs, 0);
        check_eq("rst_hs_d_pos_pol", z_hs_d, 0);

        // Delay history: one sample back is the reset-state flags, two back is the flushed stage
        fp1 = 3'b111; fp2 = 3'b011;
        sp1 = 3'b111; sp2 = 3'b011;

        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 1; k <= 900; k++) begin
            tick();
            // Default instance: first line
            if (k == 1) begin
                check_eq("k1_drawx", f_x, 1);
                check_eq("k1_drawy", f_y, 0);
                check_eq("k1_blank", f_blank, 1);
                check_eq("k1_hs", f_hs, 1);
                check_eq("k1_vs", f_vs, 1);
                check_eq("k1_line_start", f_ls, 0);
                check_eq("k1_frame_count", f_fc, 0);
                check_eq("k1_blank_d", f_blank_d, 0);
            end
            if (k == 2) check_eq("k2_blank_d", f_blank_d, 1);
            if (k == 639) begin
                check_eq("x639_drawx", f_x, 639);
                check_eq("x639_blank", f_blank, 1);
            end
            if (k == 640) check_eq("x640_blank", f_blank, 0);
            if (k == 800) begin
                check_eq("wrap_drawx", f_x, 0);
                check_eq("wrap_drawy", f_y, 1);
                check_eq("wrap_line_start", f_ls, 1);
            end
            if (k == 801) check_eq("wrap_line_start_drop", f_ls, 0);
            if (k <= 800) begin
                if (f_hs == 1'b0) begin
                    f_hs_low++;
                    if (f_hs_first < 0) f_hs_first = k;
                end
                if (f_ls == 1'b1) f_ls_cnt++;
            end
            if ({f_blank_d, f_hs_d, f_vs_d} !== fp2) f_align++;
            fp2 = fp1;
            fp1 = {f_blank, f_hs, f_vs};

            // Small instance: frame-level behaviour
            if (k == 7)  check_eq("sm_blank_x7y0", s_blank, 1);
            if (k == 8)  check_eq("sm_blank_x8y0", s_blank, 0);
            if (k == 80) check_eq("sm_blank_x0y5", s_blank, 1);
            if (k == 96) check_eq("sm_blank_x0y6", s_blank, 0);
            if (k <= 176 && s_vs == 1'b0) begin
                s_vs_low++;
                if (s_vs_first < 0) s_vs_first = k;
            end
            if (k == 175) begin
                check_eq("sm_fs_before", s_fs, 0);
                check_eq("sm_fc_before", s_fc, 0);
            end
            if (k == 176) begin
                check_eq("sm_fs_at_wrap", s_fs, 1);
                check_eq("sm_fc_at_wrap", s_fc, 1);
                check_eq("sm_xy_at_wrap", {s_x, s_y}, 0);
            end
            if (k == 177) check_eq("sm_fs_after", s_fs, 0);
            if (s_fs == 1'b1) s_fs_cnt++;
            if (s_ls == 1'b1) s_ls_cnt++;
            if ({s_blank_d, s_hs_d, s_vs_d} !== sp2) s_align++;
            sp2 = sp1;
            sp1 = {s_blank, s_hs, s_vs};

            // Zero-delay, active-high instance
            if (k <= 16 && z_hs == 1'b1) begin
                z_hs_high++;
                if (z_hs_first < 0) z_hs_first = k;
            end
            if (k <= 176 && z_vs == 1'b1) z_vs_high++;
            if ({z_blank_d, z_hs_d, z_vs_d} !== {z_blank, z_hs, z_vs}) z_align++;
        end

        check_eq("hs_low_clocks", f_hs_low, 96);
        check_eq("hs_first_low_x", f_hs_first, 656);
        check_eq("line_start_pulses", f_ls_cnt, 1);
        check_eq("full_delay2_align_errs", f_align, 0);
        check_eq("sm_vs_low_clocks", s_vs_low, 32);
        check_eq("sm_vs_first_low_k", s_vs_first, 112);
        check_eq("sm_frame_start_pulses", s_fs_cnt, 5);
        check_eq("sm_frame_count_k900", s_fc, 5);
        check_eq("sm_line_start_pulses", s_ls_cnt, 56);
        check_eq("sm_delay2_align_errs", s_align, 0);
        check_eq("zero_hs_high_clocks", z_hs_high, 3);
        check_eq("zero_hs_first_high_x", z_hs_first, 10);
        check_eq("zero_vs_high_clocks", z_vs_high, 32);
        check_eq("zero_delay_align_errs", z_align, 0);

        // Mid-frame reset on the small instance at (5,4)
        found = 0;
        for (int n = 0; n < 400 && found == 0; n++) begin
            tick();
            if (s_x == 10'd5 && s_y == 10'd4) found = 1;
        end
        check_eq("sm_reach_x5y4", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_drawx", s_x, 0);
        check_eq("mid_rst_drawy", s_y, 0);
        check_eq("mid_rst_frame_count", s_fc, 0);
        check_eq("mid_rst_blank_d", s_blank_d, 0);
        check_eq("mid_rst_hs_d", s_hs_d, 1);
        check_eq("mid_rst_vs_d", s_vs_d, 1);
        check_eq("mid_rst_full_xy", {f_x, f_y}, 0);

        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int n = 1; n <= 400 && lat == 0; n++) begin
            tick();
            if (s_fs == 1'b1) begin
                lat = n;
                check_eq("mid_rst_fc_at_fs", s_fc, 1);
            end
        end
        check_eq("mid_rst_fs_latency", lat, 176);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
